// File: rtl/semaforo_pkg.sv
// ---------------------------------------------------------------------------
// semaforo_pkg
//   Shared definitions for the traffic-light controller and the pedestrian
//   button conditioner that sits in front of it.
//   - Light codes for the one-hot light buses {vermelho, amarelo, verde}.
//   - Pedestrian-request FSM state encoding (2 bits).
//   - Phase duration constants, in clock cycles, used by the light controller.
//   - is_red(): exact match on the red code. Any non-one-hot value is "not red".
// ---------------------------------------------------------------------------
package semaforo_pkg;

    // One-hot light codes {vermelho, amarelo, verde}
    localparam logic [2:0] LUZ_VERDE    = 3'b001;
    localparam logic [2:0] LUZ_AMARELO  = 3'b010;
    localparam logic [2:0] LUZ_VERMELHO = 3'b100;

    // Phase durations, in clock cycles
    localparam logic [7:0] VERDE    = 8'd10;
    localparam logic [7:0] AMARELO  = 8'd3;
    localparam logic [7:0] VERMELHO = 8'd8;

    // Pedestrian request FSM
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_SERVING  = 2'd2,
        ST_COOLDOWN = 2'd3
    } ped_state_t;

    // Only the exact red code counts as red. Corrupted or multi-hot values are
    // deliberately treated as "not red" so a glitch cannot complete a request.
    function automatic logic is_red(input logic [2:0] luz);
        return (luz == LUZ_VERMELHO);
    endfunction

endpackage

// File: rtl/botao_pedestre_if.sv
// ---------------------------------------------------------------------------
// botao_pedestre_if
//   Signal bundle between the pedestrian button conditioner and its
//   surroundings (button pad, traffic-light controller, observers).
//   btn_raw    : raw asynchronous push-button level, 1 = pressed
//   A          : light A state from the controller, one-hot {R, Y, G}
//   bt         : request level towards the controller
//   pending    : request in flight (PENDING or SERVING)
//   served_cnt : number of served requests, wraps 255 -> 0
//   modport master : environment side (drives button and light A)
//   modport slave  : conditioner side (drives bt, pending, served_cnt)
// ---------------------------------------------------------------------------
interface botao_pedestre_if;

    logic       btn_raw;
    logic [2:0] A;
    logic       bt;
    logic       pending;
    logic [7:0] served_cnt;

    modport master (
        output btn_raw,
        output A,
        input  bt,
        input  pending,
        input  served_cnt
    );

    modport slave (
        input  btn_raw,
        input  A,
        output bt,
        output pending,
        output served_cnt
    );

endinterface

// File: rtl/debounce_botao.sv
// ---------------------------------------------------------------------------
// debounce_botao
//   Two-flop synchroniser followed by a level debouncer. The debounced level
//   only follows the synchronised button after it has differed from the
//   current debounced level for DEB_CYCLES consecutive cycles.
//   Parameters:
//     DEB_CYCLES : stable cycles needed to accept a new level (1..255)
//   Ports:
//     clk        : system clock, rising edge
//     rst        : asynchronous active-low reset
//     i_btn_raw  : raw asynchronous button level
//     o_btn_db   : debounced button level
// ---------------------------------------------------------------------------
module debounce_botao #(
    parameter logic [7:0] DEB_CYCLES = 8'd4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_btn_raw,
    output logic o_btn_db
);

    logic       r_sync1;
    logic       r_btn_s;
    logic       r_btn_db;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_inc;
    logic       w_differs;
    logic       w_accept;

    assign w_cnt_inc = r_cnt + 8'd1;
    assign w_differs = (r_btn_s != r_btn_db);
    // The counter never actually holds DEB_CYCLES: the level is taken on the
    // cycle the increment would reach it, which keeps the latency at
    // DEB_CYCLES cycles after synchronisation.
    assign w_accept  = w_differs && (w_cnt_inc == DEB_CYCLES);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1  <= 1'b0;
            r_btn_s  <= 1'b0;
            r_btn_db <= 1'b0;
            r_cnt    <= 8'd0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_btn_s <= r_sync1;
            if (!w_differs) begin
                r_cnt <= 8'd0;
            end else if (w_accept) begin
                r_btn_db <= r_btn_s;
                r_cnt    <= 8'd0;
            end else begin
                r_cnt <= w_cnt_inc;
            end
        end
    end

    assign o_btn_db = r_btn_db;

endmodule

// File: rtl/botao_pedestre.sv
// ---------------------------------------------------------------------------
// botao_pedestre
//   Pedestrian button conditioner in front of the traffic-light controller.
//   A debounced rising edge of the button raises a held request on bt. The
//   request is served once light A is seen red; after A leaves red a cooldown
//   window rejects further presses. Served requests are counted.
//   Parameters:
//     DEB_CYCLES : debounce length in cycles (1..255)
//     COOLDOWN   : cycles after A leaves red during which presses are ignored
//                  (0..255); the cooldown state lasts COOLDOWN+1 cycles
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-low reset, clears all state
//     bus : botao_pedestre_if.slave (btn_raw, A in; bt, pending,
//           served_cnt out)
// ---------------------------------------------------------------------------
module botao_pedestre
    import semaforo_pkg::*;
#(
    parameter logic [7:0] DEB_CYCLES = 8'd4,
    parameter logic [7:0] COOLDOWN   = 8'd6
) (
    input  logic                  clk,
    input  logic                  rst,
    botao_pedestre_if.slave       bus
);

    ped_state_t r_state;
    ped_state_t w_next;

    logic       w_btn_db;
    logic       r_btn_db_q;
    logic       w_press;
    logic       w_red;
    logic [7:0] r_cd_cnt;
    logic [7:0] r_served;
    logic       w_serve;
    logic       w_cd_load;
    logic       w_cd_dec;

    debounce_botao #(
        .DEB_CYCLES (DEB_CYCLES)
    ) u_deb (
        .clk       (clk),
        .rst       (rst),
        .i_btn_raw (bus.btn_raw),
        .o_btn_db  (w_btn_db)
    );

    // Rising edge of the debounced level only; releases are not events.
    assign w_press = w_btn_db & ~r_btn_db_q;
    assign w_red   = is_red(bus.A);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and transition strobes. Presses outside IDLE are dropped
    // simply by not being looked at.
    always_comb begin
        w_next    = r_state;
        w_serve   = 1'b0;
        w_cd_load = 1'b0;
        w_cd_dec  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_press) begin
                    w_next = ST_PENDING;
                end
            end
            ST_PENDING: begin
                if (w_red) begin
                    w_next  = ST_SERVING;
                    w_serve = 1'b1;
                end
            end
            ST_SERVING: begin
                if (!w_red) begin
                    w_next    = ST_COOLDOWN;
                    w_cd_load = 1'b1;
                end
            end
            ST_COOLDOWN: begin
                if (r_cd_cnt == 8'd0) begin
                    w_next = ST_IDLE;
                end else begin
                    w_cd_dec = 1'b1;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Edge-detect delay, cooldown counter and served counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_btn_db_q <= 1'b0;
            r_cd_cnt   <= 8'd0;
            r_served   <= 8'd0;
        end else begin
            r_btn_db_q <= w_btn_db;
            if (w_cd_load) begin
                r_cd_cnt <= COOLDOWN;
            end else if (w_cd_dec) begin
                r_cd_cnt <= r_cd_cnt - 8'd1;
            end
            if (w_serve) begin
                // Free-running wrap at 255 -> 0
                r_served <= r_served + 8'd1;
            end
        end
    end

    // Outputs decoded straight from the state register, no extra flop
    assign bus.bt         = (r_state == ST_PENDING);
    assign bus.pending    = (r_state == ST_PENDING) || (r_state == ST_SERVING);
    assign bus.served_cnt = r_served;

endmodule

// File: tb/tb_botao_pedestre.sv
// ---------------------------------------------------------------------------
// tb_botao_pedestre
//   Bench for botao_pedestre with DEB_CYCLES=4, COOLDOWN=6.
//   Step c drives inputs just after a rising edge; they are sampled by edge c
//   and outputs are compared 1 time unit after that edge.
// ---------------------------------------------------------------------------
module tb_botao_pedestre;
    import semaforo_pkg::*;

    logic clk = 1'b0;
    logic rst;

    botao_pedestre_if bus ();

    botao_pedestre #(
        .DEB_CYCLES (8'd4),
        .COOLDOWN   (8'd6)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // One scenario: button pattern per step, red window on A (yellow for the
    // two steps before red), A value outside those, and up to two expected
    // windows [rise, fall) for bt and [rise, pfall) for pending.
    typedef struct {
        logic [63:0] mask;
        int          r0;
        int          rlen;
        logic [2:0]  a_idle;
        int          rise1;
        int          fall1;
        int          pfall1;
        int          rise2;
        int          fall2;
        int          pfall2;
        int          ncyc;
        logic [7:0]  exp_cnt;
    } vec_t;

    typedef struct packed {
        logic bt;
        logic pend;
    } exp_t;

    vec_t vecs[7];
    exp_t sb[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, req);
        end
    endtask

    task automatic do_reset();
        rst         = 1'b0;
        bus.btn_raw = 1'b1;
        bus.A       = LUZ_VERDE;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("rst_bt_%0d", k), {31'd0, bus.bt}, 0);
            check($sformatf("rst_pend_%0d", k), {31'd0, bus.pending}, 0);
            check($sformatf("rst_cnt_%0d", k), {24'd0, bus.served_cnt}, 0);
        end
        rst = 1'b1;
    endtask

    function automatic logic [2:0] a_of(input vec_t v, input int c);
        if (c >= v.r0 && c < v.r0 + v.rlen) return LUZ_VERMELHO;
        if (c >= v.r0 - 2 && c < v.r0)      return LUZ_AMARELO;
        return v.a_idle;
    endfunction

    task automatic step(input logic b, input logic [2:0] a);
        bus.btn_raw = b;
        bus.A       = a;
        @(posedge clk);
        #1;
    endtask

    initial begin
        exp_t e;
        int   highs;
        int   rise;
        rst         = 1'b0;
        bus.btn_raw = 1'b0;
        bus.A       = LUZ_VERDE;

        //           mask            r0    rlen a_idle  r1 f1 p1  r2 f2 p2  N   cnt
        vecs[0] = '{64'h0000_0FFF,   12,   2,   3'b001, 6, 12, 14, 0, 0, 0, 40, 8'd1};
        vecs[1] = '{64'h0000_03FF,   0,    12,  3'b001, 6, 7,  12, 0, 0, 0, 30, 8'd1};
        vecs[2] = '{64'h0000_E0C1,   1000, 0,   3'b001, 0, 0,  0,  0, 0, 0, 30, 8'd0};
        vecs[3] = '{64'h0000_000F,   1000, 0,   3'b001, 6, 30, 30, 0, 0, 0, 30, 8'd0};
        vecs[4] = '{64'h007F_83FF,   12,   2,   3'b001, 6, 12, 14, 0, 0, 0, 40, 8'd1};
        vecs[5] = '{64'h00FF_03FF,   12,   2,   3'b001, 6, 12, 14, 22, 36, 36, 36, 8'd1};
        vecs[6] = '{64'h0000_03FF,   1000, 0,   3'b110, 6, 30, 30, 0, 0, 0, 30, 8'd0};

        for (int i = 0; i < 7; i++) begin
            do_reset();
            for (int c = 0; c < vecs[i].ncyc; c++) begin
                bus.btn_raw = vecs[i].mask[c];
                bus.A       = a_of(vecs[i], c);
                e.bt   = (c >= vecs[i].rise1 && c < vecs[i].fall1) ||
                         (c >= vecs[i].rise2 && c < vecs[i].fall2);
                e.pend = (c >= vecs[i].rise1 && c < vecs[i].pfall1) ||
                         (c >= vecs[i].rise2 && c < vecs[i].pfall2);
                sb.push_back(e);
                @(posedge clk);
                #1;
                e = sb.pop_front();
                check($sformatf("v%0d_bt_c%0d", i, c), {31'd0, bus.bt}, {31'd0, e.bt});
                check($sformatf("v%0d_pend_c%0d", i, c), {31'd0, bus.pending}, {31'd0, e.pend});
            end
            check($sformatf("v%0d_cnt", i), {24'd0, bus.served_cnt}, {24'd0, vecs[i].exp_cnt});
        end

        // 256 presses with A red: bt high one cycle each, counter wraps to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            highs = 0;
            for (int c = 0; c < 8; c++) begin
                step(1'b1, LUZ_VERMELHO);
                if (bus.bt === 1'b1) highs++;
            end
            for (int c = 0; c < 12; c++) begin
                step(1'b0, LUZ_VERDE);
                if (bus.bt === 1'b1) highs++;
            end
            check($sformatf("wrap_bt_cycles_%0d", i), highs, 1);
            check($sformatf("wrap_cnt_%0d", i), {24'd0, bus.served_cnt}, (i + 1) % 256);
        end

        // Asynchronous reset while PENDING
        do_reset();
        for (int c = 0; c < 8; c++) step(1'b1, LUZ_VERMELHO);
        for (int c = 0; c < 12; c++) step(1'b0, LUZ_VERDE);
        check("ar_cnt_before", {24'd0, bus.served_cnt}, 1);
        rise = -1;
        for (int c = 0; c < 20 && rise < 0; c++) begin
            step(1'b1, LUZ_VERDE);
            if (bus.bt === 1'b1) rise = c;
        end
        check("ar_bt_rise", rise, 6);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("ar_bt_async", {31'd0, bus.bt}, 0);
        check("ar_pend_async", {31'd0, bus.pending}, 0);
        check("ar_cnt_async", {24'd0, bus.served_cnt}, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        rise = -1;
        for (int c = 0; c < 16; c++) begin
            step(1'b1, LUZ_VERDE);
            if (c == 0) check("ar_idle_after", {31'd0, bus.pending}, 0);
            if (bus.bt === 1'b1 && rise < 0) rise = c;
        end
        check("ar_rearm_rise", rise, 6);
        check("ar_cnt_after", {24'd0, bus.served_cnt}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
